load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, default 32, byte address width; DATA_WIDTH, default 32, data word width (fixed at 32 in this revision).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core presents an access.
REQ-005 SHALL have port req_ready, output, 1, unit can accept an access.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, ADDRESS_WIDTH, byte address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, DATA_WIDTH, extended load result (0 for stores).
REQ-012 SHALL have port rsp_err, output, 1, access faulted; valid with rsp_valid.
REQ-013 SHALL have port mem_valid, output, 1, bus request.
REQ-014 SHALL have port mem_ready, input, 1, bus accepts the request.
REQ-015 SHALL have port mem_write, output, 1, bus write enable.
REQ-016 SHALL have port mem_addr, output, ADDRESS_WIDTH, word-aligned address (bits [1:0] = 0).
REQ-017 SHALL have port mem_wdata, output, DATA_WIDTH, lane-shifted store data.
REQ-018 SHALL have port mem_be, output, 4, byte-lane enables.
REQ-019 SHALL have port mem_rvalid, input, 1, read data returned.
REQ-020 SHALL have port mem_rdata, input, DATA_WIDTH, read word.

Function
REQ-021 SHALL implement FSM IDLE -> BUS -> (load: WAIT) -> RESP -> IDLE.
REQ-022 IDLE: req_ready=1; on req_valid, register all req_* fields and go to BUS; no other state asserts req_ready.
REQ-023 BUS: mem_valid=1; mem_* held stable until mem_ready; on mem_ready go to WAIT for loads, RESP for stores.
REQ-024 WAIT: capture mem_rdata on mem_rvalid, go to RESP; mem_rvalid outside WAIT is ignored.
REQ-025 RESP: rsp_valid=1 for exactly one cycle, then IDLE; back-to-back requests are accepted from the following cycle.
REQ-026 Minimum latency: store accepted cycle N, rsp_valid cycle N+2 (mem_ready high in N+1); load rsp_valid cycle N+3 (mem_rvalid in N+2).
REQ-027 mem_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
REQ-028 mem_wdata: store byte/half replicated across all lanes; word passed unchanged.
REQ-029 Loads: select lane by addr[1:0]; B/H sign-extend; BU/HU zero-extend to 32 bits.
REQ-030 Unsupported funct3 (011, 110, 111) SHALL complete with rsp_err=1, no bus transaction, rsp_valid at cycle N+1.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, req_ready 1, mem_valid 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_be 0, mem_write 0.
REQ-032 Reset mid-transaction SHALL abandon it without a response; no bus output is held over after release.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined: H at addr[0]=1 or W at addr[1:0]!=0 SHALL give rsp_err=1 at N+1 with no mem_valid.
REQ-034 Without LSU_MISALIGN_TRAP_EN: misaligned offsets SHALL be forced to the aligned offset (H: addr[0]=0; W: addr[1:0]=0); rsp_err is only for REQ-030.

Structure
REQ-035 Shared package lsu_pkg SHALL hold the funct3 encodings, the FSM state enum and the lane-mask constants.
REQ-036 Sub-module load_extend SHALL be combinational: lane selection and sign/zero extension (REQ-029).

Verification
REQ-037 SW addr 0x100, wdata 0xDEADBEEF, mem_ready immediate -> mem_be 1111, mem_wdata 0xDEADBEEF, rsp_valid at N+2.
REQ-038 SB addr 0x103, wdata 0x000000A5 -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5.
REQ-039 LB addr 0x102, mem_rdata 0x12805634 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 LH addr 0x102, mem_ready delayed 3 cycles, mem_rdata 0x8001FFFF -> mem_* stable throughout, rsp_rdata 0xFFFF8001.
REQ-041 LW addr 0x101 -> with the macro: rsp_err=1, no mem_valid; without the macro: mem_addr 0x100, rsp_err=0.
REQ-042 rst_n low while in WAIT -> next cycle IDLE, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-lane masks and the offset/lane helpers used by the top level.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Offset actually used on the bus: halves and words snap down to alignment.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return lo;
      2'b01:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return LANE_B << off;
      2'b01:   return LANE_H << off;
      default: return LANE_W;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: selects the addressed lane of the returned
// word and sign- or zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, IDLE -> BUS -> (WAIT) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  state_e                state;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [1:0]            off;
  logic                  trap;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    off = eff_offset(req_funct3, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = !f3_supported(req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    trap = !f3_supported(req_funct3);
`endif
    case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  load_extend u_load_extend (
    .word   (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      funct3_q  <= '0;
      offset_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            funct3_q  <= req_funct3;
            offset_q  <= off;
            // Faulting accesses skip the bus and respond on the next cycle.
            if (trap) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= S_BUS;
              mem_valid <= 1'b1;
              mem_write <= req_write;
              mem_addr  <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_be    <= lane_mask(req_funct3, off);
              mem_wdata <= store_data;
            end
          end
        end
        S_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_be    <= '0;
            if (mem_write) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: random and directed accesses against a
// transaction-level reference model with a randomly stalling memory responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_write, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit        write;
    bit [2:0]  f3;
    bit [31:0] addr, wdata, rdata;
    int        rdy, rv;
    bit        err;
    bit [31:0] maddr, wd, exp_rd;
    bit [3:0]  be;
    int        lat, acc;
  } txn_t;

  txn_t q[$];

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the access is described by its size in bytes and byte offset.
  function automatic txn_t model(input txn_t t);
    int size, off;
    bit [31:0] mask, v;
    t.err    = !(t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size     = 1 << t.f3[1:0];
    off      = int'(t.addr % 4);
    if (!t.err && (off % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      t.err = 1'b1;
`else
      off = off - (off % size);
`endif
    end
    t.maddr  = t.addr - (t.addr % 4);
    t.be     = 4'(((1 << size) - 1) << off);
    t.wd     = (size == 1) ? t.wdata[7:0] * 32'h01010101 :
               (size == 2) ? t.wdata[15:0] * 32'h00010001 : t.wdata;
    t.exp_rd = 32'h0;
    if (t.err) t.lat = 1;
    else if (t.write) t.lat = 2 + t.rdy;
    else begin
      t.lat = 3 + t.rdy + t.rv;
      mask  = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
      v     = (t.rdata >> (8 * off)) & mask;
      if (!t.f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      t.exp_rd = v;
    end
    return t;
  endfunction

  function automatic txn_t mk(input bit w, input bit [2:0] f3, input bit [31:0] a,
                              input bit [31:0] wd, input bit [31:0] rd,
                              input int rdy, input int rv);
    txn_t t;
    t.write = w; t.f3 = f3; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.rdy = rdy; t.rv = rv; t.acc = 0;
    return model(t);
  endfunction

  task automatic issue(input txn_t t, input bit b2b);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = t.write; req_funct3 = t.f3;
    req_addr = t.addr; req_wdata = t.wdata;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        errors++; checks++;
        $display("FAIL accept_timeout actual=stalled required=req_ready");
        req_valid = 1'b0;
        return;
      end
    end
    t.acc = cyc;
    @(posedge clk);
    q.push_back(t);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (!b2b) begin
      n = 0;
      while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
      if (q.size() != 0) begin
        errors++; checks++;
        $display("FAIL rsp_timeout actual=none required=rsp_valid");
      end
    end
  endtask

  // Compare process: bus side and response side against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, q.size() == 0);
      if (mem_valid) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL bus_spurious actual=mem_valid required=idle_bus");
        end else if (q[0].err) begin
          errors++; checks++;
          $display("FAIL bus_on_fault actual=mem_valid required=no_bus");
        end else begin
          chk("mem_addr", mem_addr, q[0].maddr);
          chk("mem_be", mem_be, q[0].be);
          chk("mem_write", mem_write, q[0].write);
          if (q[0].write) chk("mem_wdata", mem_wdata, q[0].wd);
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL rsp_spurious actual=rsp_valid required=none");
        end else begin
          chk("rsp_rdata", rsp_rdata, q[0].exp_rd);
          chk("rsp_err", rsp_err, q[0].err);
          chk("rsp_latency", cyc - q[0].acc, q[0].lat);
          void'(q.pop_front());
        end
      end
    end
  end

  // Memory responder: stalls mem_ready, delays mem_rvalid and injects stray rvalids outside WAIT.
  initial begin
    int phase, k, j;
    phase = 0; k = 0; j = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!rst_n || q.size() == 0) begin
        phase = 0;
        if (rst_n && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
      end else begin
        if (phase == 0) begin
          if (mem_valid) begin phase = 1; k = 0; end
          else if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
        end
        if (phase == 1) begin
          if (k >= q[0].rdy) begin
            mem_ready = 1'b1;
            phase = q[0].write ? 0 : 2;
            j = 0;
          end else begin
            k++;
            if ($urandom_range(0, 2) == 0) mem_rvalid = 1'b1;
          end
        end else if (phase == 2) begin
          if (j >= q[0].rv) begin
            mem_rvalid = 1'b1; mem_rdata = q[0].rdata; phase = 0;
          end else j++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    bit w;
    bit [2:0] f3;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_write", mem_write, 1'b0);
    #1 rst_n = 1'b1;

    // Hand-computed values that pin the reference model.
    t = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    chk("pin_sw_be", t.be, 4'b1111); chk("pin_sw_wd", t.wd, 32'hDEADBEEF);
    chk("pin_sw_lat", t.lat, 2);
    t = mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
    chk("pin_sb_addr", t.maddr, 32'h100); chk("pin_sb_be", t.be, 4'b1000);
    chk("pin_sb_wd", t.wd, 32'hA5A5A5A5);
    t = mk(0, 3'b000, 32'h102, 0, 32'h12805634, 0, 0);
    chk("pin_lb", t.exp_rd, 32'hFFFFFF80); chk("pin_lb_lat", t.lat, 3);
    t = mk(0, 3'b100, 32'h102, 0, 32'h12805634, 0, 0);
    chk("pin_lbu", t.exp_rd, 32'h00000080);
    t = mk(0, 3'b001, 32'h102, 0, 32'h8001FFFF, 3, 0);
    chk("pin_lh", t.exp_rd, 32'hFFFF8001);
    t = mk(0, 3'b010, 32'h101, 0, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("pin_lw_mis_err", t.err, 1'b1); chk("pin_lw_mis_lat", t.lat, 1);
`else
    chk("pin_lw_mis_addr", t.maddr, 32'h100); chk("pin_lw_mis_err", t.err, 1'b0);
`endif

    // Directed accesses through the unit.
    issue(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0), 0);
    issue(mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0), 0);
    issue(mk(0, 3'b000, 32'h102, 0, 32'h12805634, 0, 0), 0);
    issue(mk(0, 3'b100, 32'h102, 0, 32'h12805634, 0, 0), 0);
    issue(mk(0, 3'b001, 32'h102, 0, 32'h8001FFFF, 3, 0), 0);
    issue(mk(0, 3'b010, 32'h101, 0, 32'h55AA1234, 0, 0), 0);
    issue(mk(1, 3'b001, 32'h203, 32'h0000BEEF, 0, 1, 0), 0);
    issue(mk(0, 3'b011, 32'h100, 0, 0, 0, 0), 0);
    issue(mk(1, 3'b111, 32'h104, 32'h1, 0, 0, 0), 1);
    issue(mk(0, 3'b110, 32'h108, 0, 0, 0, 0), 1);
    issue(mk(1, 3'b010, 32'h10C, 32'hCAFEF00D, 0, 0, 0), 1);
    issue(mk(0, 3'b101, 32'h10E, 0, 32'hF00DCAFE, 0, 0), 0);

    // Randomised accesses, some issued back-to-back.
    for (int i = 0; i < 250; i++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom);
      if (w && (f3 == 3'b100 || f3 == 3'b101)) f3 = {1'b0, f3[1:0]};
      issue(mk(w, f3, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
            $urandom_range(0, 1) == 1);
    end
    begin
      int n = 0;
      while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    end

    // Reset while a load waits for its read data.
    issue(mk(0, 3'b010, 32'h300, 0, 32'h12345678, 0, 8), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_req_ready", req_ready, 1'b1);
    chk("wrst_mem_valid", mem_valid, 1'b0);
    chk("wrst_rsp_valid", rsp_valid, 1'b0);
    chk("wrst_mem_be", mem_be, 4'h0);
    chk("wrst_rsp_rdata", rsp_rdata, 32'h0);
    q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(mk(0, 3'b000, 32'h401, 0, 32'h0000FE00, 1, 1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
